// File: rtl/map_pkg.sv
// Shared constants and types for the map RAM arbiter: map geometry, cell and
// orientation encodings, grant and read-tag types.
package map_pkg;

  localparam int ROWS         = 10;
  localparam int COLS         = 20;
  localparam int ADDR_W       = 8;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [2:0] {
    CELL_EMPTY   = 3'd0,
    CELL_WALL    = 3'd1,
    CELL_BARRIER = 3'd2,
    CELL_TRASH   = 3'd7
  } cell_e;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    SOUTH = 2'd1,
    EAST  = 2'd2,
    WEST  = 2'd3
  } orient_e;

  // Reads of cells outside the playfield look like walls to both requesters.
  localparam logic [2:0] OOB_VALUE = CELL_WALL;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WORLD = 2'd1,
    GNT_VGA   = 2'd2
  } grant_e;

  typedef enum logic {
    PORT_WORLD = 1'b0,
    PORT_VGA   = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  oob;
  } rd_tag_t;

  function automatic grant_e pick_grant(input logic v_elig, input logic w_elig,
                                        input logic starved);
    if (v_elig && !(w_elig && starved)) return GNT_VGA;
    if (w_elig)                         return GNT_WORLD;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/map_addr_calc.sv
// Combinational (row, col) to linear RAM address with playfield range check.
module map_addr_calc
  import map_pkg::*;
#(
  parameter int ROWS   = map_pkg::ROWS,
  parameter int COLS   = map_pkg::COLS,
  parameter int ADDR_W = map_pkg::ADDR_W
) (
  input  logic [5:0]        row_i,
  input  logic [5:0]        col_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              oob_o
);

  localparam int CW = ADDR_W + 4;

  logic [CW-1:0] lin;
  logic          row_bad;
  logic          col_bad;
  logic          addr_ovf;

  always_comb begin
    lin      = CW'(row_i) * CW'(COLS) + CW'(col_i);
    row_bad  = (row_i == 6'd0) || (32'(row_i) > ROWS);
    col_bad  = (col_i == 6'd0) || (32'(col_i) > COLS);
    // Guards against a parameter set whose map does not fit the RAM.
    addr_ovf = |lin[CW-1:ADDR_W];
    oob_o    = row_bad | col_bad | addr_ovf;
    addr_o   = lin[ADDR_W-1:0];
  end

endmodule

// File: rtl/map_arbiter.sv
// Single-port map RAM arbiter: VGA has fixed priority, the world port has a
// starvation guard; reads return on a fixed two-edge latency.
module map_arbiter
  import map_pkg::*;
#(
  parameter int         ROWS         = map_pkg::ROWS,
  parameter int         COLS         = map_pkg::COLS,
  parameter int         ADDR_W       = map_pkg::ADDR_W,
  parameter int         STARVE_LIMIT = map_pkg::STARVE_LIMIT,
  parameter logic [2:0] OOB_VALUE    = map_pkg::OOB_VALUE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_req,
  input  logic              w_we,
  input  logic [5:0]        w_row,
  input  logic [5:0]        w_col,
  input  logic [2:0]        w_wdata,
  output logic              w_ack,
  output logic              w_rvalid,
  output logic [2:0]        w_rdata,
  input  logic              v_req,
  input  logic [5:0]        v_row,
  input  logic [5:0]        v_col,
  output logic              v_ack,
  output logic              v_rvalid,
  output logic [2:0]        v_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] v_addr;
  logic              w_oob;
  logic              v_oob;

  map_addr_calc #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) u_w_addr (
    .row_i  (w_row),
    .col_i  (w_col),
    .addr_o (w_addr),
    .oob_o  (w_oob)
  );

  map_addr_calc #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) u_v_addr (
    .row_i  (v_row),
    .col_i  (v_col),
    .addr_o (v_addr),
    .oob_o  (v_oob)
  );

  logic              w_ack_q,     w_ack_d;
  logic              v_ack_q,     v_ack_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [2:0]        mem_wdata_q, mem_wdata_d;
  logic              w_rvalid_q,  w_rvalid_d;
  logic              v_rvalid_q,  v_rvalid_d;
  logic [2:0]        w_rdata_q,   w_rdata_d;
  logic [2:0]        v_rdata_q,   v_rdata_d;
  logic [SW-1:0]     starve_q,    starve_d;
  rd_tag_t           tag1_q,      tag1_d;
  rd_tag_t           tag2_q,      tag2_d;

  grant_e            gnt;
  logic              w_elig;
  logic              v_elig;
  logic              starved;
  logic [2:0]        rd_sel;

  always_comb begin
    // A port whose ack is still high is mid-handshake and must not be re-granted.
    w_elig  = w_req & ~w_ack_q;
    v_elig  = v_req & ~v_ack_q;
    starved = (starve_q == SW'(STARVE_LIMIT));
    gnt     = pick_grant(v_elig, w_elig, starved);

    if (gnt == GNT_WORLD || !w_req) begin
      starve_d = '0;
    end else if (gnt == GNT_VGA && !starved) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    w_ack_d     = 1'b0;
    v_ack_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    tag1_d      = '{valid: 1'b0, port: PORT_WORLD, oob: 1'b0};

    case (gnt)
      GNT_WORLD: begin
        w_ack_d  = 1'b1;
        mem_en_d = ~w_oob;
        if (!w_oob) begin
          mem_addr_d  = w_addr;
          mem_we_d    = w_we;
          mem_wdata_d = w_wdata;
        end
        tag1_d = '{valid: ~w_we, port: PORT_WORLD, oob: w_oob};
      end
      GNT_VGA: begin
        v_ack_d  = 1'b1;
        mem_en_d = ~v_oob;
        if (!v_oob) begin
          mem_addr_d = v_addr;
        end
        tag1_d = '{valid: 1'b1, port: PORT_VGA, oob: v_oob};
      end
      default: ;
    endcase

    tag2_d = tag1_q;

    // OOB reads never touched the RAM, so their data is substituted here.
    rd_sel     = tag2_q.oob ? OOB_VALUE : mem_rdata;
    w_rvalid_d = tag2_q.valid && (tag2_q.port == PORT_WORLD);
    v_rvalid_d = tag2_q.valid && (tag2_q.port == PORT_VGA);
    w_rdata_d  = w_rvalid_d ? rd_sel : 3'd0;
    v_rdata_d  = v_rvalid_d ? rd_sel : 3'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_ack_q     <= 1'b0;
      v_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      w_rvalid_q  <= 1'b0;
      v_rvalid_q  <= 1'b0;
      w_rdata_q   <= '0;
      v_rdata_q   <= '0;
      starve_q    <= '0;
      tag1_q      <= '{valid: 1'b0, port: PORT_WORLD, oob: 1'b0};
      tag2_q      <= '{valid: 1'b0, port: PORT_WORLD, oob: 1'b0};
    end else begin
      w_ack_q     <= w_ack_d;
      v_ack_q     <= v_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      w_rvalid_q  <= w_rvalid_d;
      v_rvalid_q  <= v_rvalid_d;
      w_rdata_q   <= w_rdata_d;
      v_rdata_q   <= v_rdata_d;
      starve_q    <= starve_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

  assign w_ack     = w_ack_q;
  assign v_ack     = v_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign w_rvalid  = w_rvalid_q;
  assign v_rvalid  = v_rvalid_q;
  assign w_rdata   = w_rdata_q;
  assign v_rdata   = v_rdata_q;

endmodule

// File: tb/tb_map_arbiter.sv
// Directed bench for map_arbiter with a behavioural registered-output RAM and a
// read-return scoreboard.
module tb_map_arbiter;
  import map_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       w_req = 1'b0, w_we = 1'b0;
  logic [5:0] w_row = '0, w_col = '0;
  logic [2:0] w_wdata = '0;
  logic       w_ack, w_rvalid;
  logic [2:0] w_rdata;
  logic       v_req = 1'b0;
  logic [5:0] v_row = '0, v_col = '0;
  logic       v_ack, v_rvalid;
  logic [2:0] v_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr;
  logic [2:0] mem_wdata;
  logic [2:0] ram_q = '0;
  logic       pl_init = 1'b0;

  logic [2:0] ram    [256];
  logic [2:0] shadow [256];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    int         port;
    logic [2:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  logic m_vack = 1'b0, m_wack = 1'b0;
  int   m_starve = 0;

  map_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .w_req     (w_req),
    .w_we      (w_we),
    .w_row     (w_row),
    .w_col     (w_col),
    .w_wdata   (w_wdata),
    .w_ack     (w_ack),
    .w_rvalid  (w_rvalid),
    .w_rdata   (w_rdata),
    .v_req     (v_req),
    .v_row     (v_row),
    .v_col     (v_col),
    .v_ack     (v_ack),
    .v_rvalid  (v_rvalid),
    .v_rdata   (v_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (ram_q)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [2:0] init_val(input int a);
    case (a)
      21:      return 3'd7;
      22:      return 3'd5;
      45:      return 3'd6;
      default: return 3'((a * 3 + 1) % 8);
    endcase
  endfunction

  // Registered-output RAM; data bus is scrambled on cycles without a read.
  always @(posedge clock) begin
    if (pl_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
      ram_q <= 3'($urandom);
    end else if (mem_en) begin
      ram_q <= ram[mem_addr];
    end else begin
      ram_q <= 3'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rv_check(input int port, input logic [2:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      check("rvalid_spurious", (port == 1) ? v_rvalid : w_rvalid, 0);
    end else begin
      e = sb.pop_front();
      check("rvalid_cycle", cyc, e.due);
      check("rvalid_port", port, e.port);
      check("rdata", d, e.data);
    end
  endtask

  always @(negedge clock) begin
    if (w_rvalid) rv_check(0, w_rdata);
    if (v_rvalid) rv_check(1, v_rdata);
    if (!w_rvalid && !v_rvalid && sb.size() != 0 && sb[0].due <= cyc) begin
      check("rvalid_missing", w_rvalid | v_rvalid, 1);
      sb.delete(0);
    end
  end

  task automatic chk_zero(input string pfx);
    check({pfx, "_w_ack"},     w_ack, 0);
    check({pfx, "_w_rvalid"},  w_rvalid, 0);
    check({pfx, "_w_rdata"},   w_rdata, 0);
    check({pfx, "_v_ack"},     v_ack, 0);
    check({pfx, "_v_rvalid"},  v_rvalid, 0);
    check({pfx, "_v_rdata"},   v_rdata, 0);
    check({pfx, "_mem_en"},    mem_en, 0);
    check({pfx, "_mem_we"},    mem_we, 0);
    check({pfx, "_mem_addr"},  mem_addr, 0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic model_reset();
    m_vack   = 1'b0;
    m_wack   = 1'b0;
    m_starve = 0;
  endtask

  // Drive one cycle of requests, predict the grant from the arbitration rules,
  // then check the registered grant outputs and queue any expected read data.
  task automatic step(input logic vr, input int vrow, input int vcol,
                      input logic wr, input logic wwe, input int wrow, input int wcol,
                      input int wd);
    int   g;
    int   addr;
    logic oob;
    logic vel, wel;
    g = 0; addr = 0; oob = 1'b0;
    v_req = vr; v_row = 6'(vrow); v_col = 6'(vcol);
    w_req = wr; w_we = wwe; w_row = 6'(wrow); w_col = 6'(wcol); w_wdata = 3'(wd);
    vel = vr && !m_vack;
    wel = wr && !m_wack;
    if (vel && wel) g = (m_starve == 4) ? 1 : 2;
    else if (vel)   g = 2;
    else if (wel)   g = 1;
    if (g == 1 || !wr) m_starve = 0;
    else if (g == 2)   m_starve = (m_starve < 4) ? m_starve + 1 : 4;
    m_vack = (g == 2);
    m_wack = (g == 1);
    if (g == 2) begin
      addr = vrow * 20 + vcol;
      oob  = (vrow < 1) || (vrow > 10) || (vcol < 1) || (vcol > 20);
    end else if (g == 1) begin
      addr = wrow * 20 + wcol;
      oob  = (wrow < 1) || (wrow > 10) || (wcol < 1) || (wcol > 20);
    end
    @(negedge clock);
    check("v_ack", v_ack, (g == 2));
    check("w_ack", w_ack, (g == 1));
    check("mem_en", mem_en, (g != 0 && !oob));
    if (g != 0 && !oob) begin
      check("mem_addr", mem_addr, addr);
      check("mem_we", mem_we, (g == 1 && wwe));
      if (g == 1 && wwe) check("mem_wdata", mem_wdata, wd);
    end
    if (g == 2 || (g == 1 && !wwe))
      sb.push_back('{port: (g == 2) ? 1 : 0, data: oob ? 3'd1 : shadow[addr], due: cyc + 2});
    else if (g == 1 && !oob)
      shadow[addr] = 3'(wd);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    @(negedge clock);
    pl_init = 1'b1;
    @(negedge clock);
    pl_init = 1'b0;
    chk_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // VGA read of preloaded cell 21
    step(1, 1, 1, 0, 0, 0, 0, 0);
    idle(4);

    // world write then VGA read-back of the same cell
    step(0, 0, 0, 1, 1, 2, 5, 0);
    idle(2);
    step(1, 2, 5, 0, 0, 0, 0, 0);
    idle(4);

    // out-of-range accesses and range boundaries
    step(0, 0, 0, 1, 0, 0, 3, 0);
    idle(3);
    step(0, 0, 0, 1, 1, 11, 4, 5);
    idle(3);
    check("oob_write_dropped", ram[224], init_val(224));
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 5, 21, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 10, 20, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 20, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 10, 20, 0);
    idle(4);

    // both requesters held high
    repeat (10) step(1, 3, 3, 1, 0, 4, 4, 0);
    idle(4);

    // alternating single requests on consecutive edges
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 1, 2, 0);
    end
    idle(4);

    // reset with a read in flight
    step(1, 1, 1, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    v_req = 1'b0;
    #1;
    chk_zero("midreset");
    sb.delete();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(5);
    step(1, 2, 2, 0, 0, 0, 0, 0);
    idle(4);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
